multicycle_control_unit: RTL

Multicycle control sequencer for the MIPS datapath. It replaces single-cycle combinational decode with a state machine that steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and holds memory requests until iHit/dHit. It adds a per-phase memory wait watchdog, sticky halt/fault states and optional performance counters. It sits between the instruction register and the datapath/cache request ports.

---
 rtl/multicycle_control_unit_if.sv | 58 +++++
 rtl/multicycle_control_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit_if.sv
// ----------------------------------------------------------------------------
// multicycle_control_unit_if
//   Bundles the signals between the multicycle control unit, the instruction
//   register, the memory request/ready handshakes and the datapath selects.
//
//   master : the control unit (drives requests, enables and selects)
//   slave  : instruction register / caches / datapath side
//
//   InstrOp, InstrFunc   opcode and funct fields of the current instruction
//   Equal                ALU operands compare equal
//   iHit, dHit           instruction / data memory ready
//   iMemRe, dMemRe, dMemWr  memory requests
//   IrWEN, PcWEN, PcSrc, JType, JReg, regWEN  register enables and PC selects
//   RegDst, MemToReg, AluSrc, ExtOp, UpperImm, RegZero, AluOp  datapath selects
//   Halt, Fault          sticky stop / error status
//   State                current sequencer state, for debug
// ----------------------------------------------------------------------------
interface multicycle_control_unit_if;
    logic [5:0] InstrOp;
    logic [5:0] InstrFunc;
    logic       Equal;
    logic       iHit;
    logic       dHit;

    logic       iMemRe;
    logic       dMemRe;
    logic       dMemWr;
    logic       IrWEN;
    logic       PcWEN;
    logic       PcSrc;
    logic       JType;
    logic       JReg;
    logic       regWEN;
    logic       RegDst;
    logic       MemToReg;
    logic       AluSrc;
    logic       ExtOp;
    logic       UpperImm;
    logic       RegZero;
    logic [3:0] AluOp;
    logic       Halt;
    logic       Fault;
    logic [2:0] State;

    modport master (
        input  InstrOp, InstrFunc, Equal, iHit, dHit,
        output iMemRe, dMemRe, dMemWr, IrWEN, PcWEN, PcSrc, JType, JReg,
               regWEN, RegDst, MemToReg, AluSrc, ExtOp, UpperImm, RegZero,
               AluOp, Halt, Fault, State
    );

    modport slave (
        output InstrOp, InstrFunc, Equal, iHit, dHit,
        input  iMemRe, dMemRe, dMemWr, IrWEN, PcWEN, PcSrc, JType, JReg,
               regWEN, RegDst, MemToReg, AluSrc, ExtOp, UpperImm, RegZero,
               AluOp, Halt, Fault, State
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// ----------------------------------------------------------------------------
// multicycle_control_unit
//   Multicycle MIPS sequencer: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
//   Memory requests are held until iHit/dHit; a per-phase wait watchdog
//   forces FAULT after MEM_TIMEOUT idle cycles (0 disables it). HALT and
//   FAULT are sticky until RST.
//
//   Ports:
//     CLK, RST   clock (rising edge), asynchronous active-high reset
//     cu         multicycle_control_unit_if.master (IR fields, hits, requests,
//                enables, datapath selects, Halt/Fault/State)
//     InstrCount, CycleCount  saturating performance counters, present only
//                when CU_PERF_COUNT_EN is defined
//
//   State codes: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5 FAULT=6.
//   AluOp codes: SLL=0 SRL=1 ADD=2 SUB=3 AND=4 OR=5 XOR=6 NOR=7 SLT=8 SLTU=9.
// ----------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned TO_W        = 8
`ifdef CU_PERF_COUNT_EN
    ,
    parameter int unsigned CNT_W       = 32
`endif
) (
    input  logic CLK,
    input  logic RST,
    multicycle_control_unit_if.master cu
`ifdef CU_PERF_COUNT_EN
    ,
    output logic [CNT_W-1:0] InstrCount,
    output logic [CNT_W-1:0] CycleCount
`endif
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5,
        FAULT  = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                           OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                           OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                           OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E,
                           OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B,
                           OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR   = 6'h08,
                           FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22,
                           FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR  = 6'h25,
                           FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT  = 6'h2A,
                           FN_SLTU = 6'h2B;

    localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2,
                           ALU_SUB = 4'd3, ALU_AND = 4'd4, ALU_OR  = 4'd5,
                           ALU_XOR = 4'd6, ALU_NOR = 4'd7, ALU_SLT = 4'd8,
                           ALU_SLTU = 4'd9;

    state_t          state;
    logic [TO_W-1:0] wait_cnt;
    logic [TO_W-1:0] wait_nxt;
    logic            wait_expired;

    logic [5:0] op;
    logic [5:0] funct;
    logic       op_ok, is_jr;
    logic       reg_dst, alu_src, ext_op, upper_imm, reg_zero, mem_to_reg;
    logic [3:0] alu_op;

    assign op    = cu.InstrOp;
    assign funct = cu.InstrFunc;

    // The wait counter counts completed idle cycles; reaching the limit on
    // this edge means MEM_TIMEOUT idle cycles have elapsed. A hit is tested
    // first, so it wins on the boundary cycle.
    assign wait_nxt     = wait_cnt + 1'b1;
    assign wait_expired = (MEM_TIMEOUT != 0) && (wait_nxt == TO_W'(MEM_TIMEOUT));

    // Instruction decode, independent of state.
    always_comb begin
        op_ok      = 1'b1;
        is_jr      = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        ext_op     = 1'b0;
        upper_imm  = 1'b0;
        reg_zero   = 1'b0;
        mem_to_reg = 1'b0;
        alu_op     = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                reg_dst = 1'b1;
                case (funct)
                    FN_SLL:          alu_op = ALU_SLL;
                    FN_SRL:          alu_op = ALU_SRL;
                    FN_JR:           is_jr  = 1'b1;
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_XOR:          alu_op = ALU_XOR;
                    FN_NOR:          alu_op = ALU_NOR;
                    FN_SLT:          alu_op = ALU_SLT;
                    FN_SLTU:         alu_op = ALU_SLTU;
                    default:         op_ok  = 1'b0;
                endcase
            end
            OP_J, OP_JAL, OP_HALT: ;
            OP_BEQ, OP_BNE: begin ext_op = 1'b1; alu_op = ALU_SUB; end
            OP_ADDI, OP_ADDIU: begin alu_src = 1'b1; ext_op = 1'b1; end
            OP_SLTI:  begin alu_src = 1'b1; ext_op = 1'b1; alu_op = ALU_SLT;  end
            OP_SLTIU: begin alu_src = 1'b1; ext_op = 1'b1; alu_op = ALU_SLTU; end
            OP_ANDI:  begin alu_src = 1'b1; alu_op = ALU_AND; end
            OP_ORI:   begin alu_src = 1'b1; alu_op = ALU_OR;  end
            OP_XORI:  begin alu_src = 1'b1; alu_op = ALU_XOR; end
            // LUI: $zero OR (imm << 16)
            OP_LUI:   begin alu_src = 1'b1; upper_imm = 1'b1; reg_zero = 1'b1; alu_op = ALU_OR; end
            OP_LW:    begin alu_src = 1'b1; ext_op = 1'b1; mem_to_reg = 1'b1; end
            OP_SW:    begin alu_src = 1'b1; ext_op = 1'b1; end
            default:  op_ok = 1'b0;
        endcase
    end

    // Output decode; everything is gated off while RST is high so an abort
    // never leaves a partial write or request on the bus.
    always_comb begin
        cu.iMemRe   = 1'b0;
        cu.dMemRe   = 1'b0;
        cu.dMemWr   = 1'b0;
        cu.IrWEN    = 1'b0;
        cu.PcWEN    = 1'b0;
        cu.PcSrc    = 1'b0;
        cu.JType    = 1'b0;
        cu.JReg     = 1'b0;
        cu.regWEN   = 1'b0;
        cu.RegDst   = 1'b0;
        cu.MemToReg = 1'b0;
        cu.AluSrc   = 1'b0;
        cu.ExtOp    = 1'b0;
        cu.UpperImm = 1'b0;
        cu.RegZero  = 1'b0;
        cu.AluOp    = '0;
        cu.Halt     = 1'b0;
        cu.Fault    = 1'b0;
        if (!RST) begin
            if (state == EXEC || state == MEM || state == WB) begin
                cu.RegDst   = reg_dst;
                cu.AluSrc   = alu_src;
                cu.ExtOp    = ext_op;
                cu.UpperImm = upper_imm;
                cu.RegZero  = reg_zero;
                cu.MemToReg = mem_to_reg;
                cu.AluOp    = alu_op;
            end
            case (state)
                FETCH: begin
                    cu.iMemRe = 1'b1;
                    cu.IrWEN  = cu.iHit;
                end
                EXEC: begin
                    case (op)
                        OP_BEQ: begin cu.PcWEN = 1'b1; cu.PcSrc = cu.Equal;  end
                        OP_BNE: begin cu.PcWEN = 1'b1; cu.PcSrc = !cu.Equal; end
                        OP_J:   begin cu.PcWEN = 1'b1; cu.JType = 1'b1; end
                        OP_JAL: begin cu.PcWEN = 1'b1; cu.JType = 1'b1; cu.regWEN = 1'b1; end
                        OP_RTYPE: begin
                            cu.PcWEN = is_jr;
                            cu.JReg  = is_jr;
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    cu.dMemRe = (op == OP_LW);
                    cu.dMemWr = (op == OP_SW);
                    cu.PcWEN  = (op == OP_SW) && cu.dHit;
                end
                WB: begin
                    cu.regWEN = 1'b1;
                    cu.PcWEN  = 1'b1;
                end
                HALT:  cu.Halt = 1'b1;
                FAULT: begin cu.Halt = 1'b1; cu.Fault = 1'b1; end
                default: ;
            endcase
        end
    end

    assign cu.State = state;

    // Sequencer. wait_cnt defaults to clear, so every state change and every
    // non-waiting cycle resets it; only an unanswered request advances it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= '0;
            case (state)
                FETCH: begin
                    if (cu.iHit)           state    <= DECODE;
                    else if (wait_expired) state    <= FAULT;
                    else                   wait_cnt <= wait_nxt;
                end
                DECODE: begin
                    if (op == OP_HALT) state <= HALT;
                    else if (!op_ok)   state <= FAULT;
                    else               state <= EXEC;
                end
                EXEC: begin
                    case (op)
                        OP_BEQ, OP_BNE, OP_J, OP_JAL: state <= FETCH;
                        OP_LW, OP_SW:                 state <= MEM;
                        OP_RTYPE:                     state <= is_jr ? FETCH : WB;
                        default:                      state <= WB;
                    endcase
                end
                MEM: begin
                    if (cu.dHit)           state    <= (op == OP_LW) ? WB : FETCH;
                    else if (wait_expired) state    <= FAULT;
                    else                   wait_cnt <= wait_nxt;
                end
                WB:      state <= FETCH;
                HALT:    state <= HALT;
                FAULT:   state <= FAULT;
                default: state <= FAULT;
            endcase
        end
    end

`ifdef CU_PERF_COUNT_EN
    // Retirement is any PC update, plus the HALT instruction itself.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            InstrCount <= '0;
            CycleCount <= '0;
        end else begin
            if (state != HALT && state != FAULT && CycleCount != '1)
                CycleCount <= CycleCount + 1'b1;
            if ((cu.PcWEN || (state == DECODE && op == OP_HALT)) && InstrCount != '1)
                InstrCount <= InstrCount + 1'b1;
        end
    end
`endif

endmodule
